// File: rtl/demod_stream_arbiter_pkg.sv
// demod_arb_pkg: shared types and constants for the demodulator stream arbiter.
//   state_e  - arbiter FSM states
//   tag_t    - in-flight tag: drop flag (priming beat) plus channel id
//   wrap_add - modular channel-index add used for round-robin search
package demod_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM
    } state_e;

    typedef struct packed {
        logic       drop;
        logic [2:0] ch;
    } tag_t;

    localparam int unsigned ANGLE_MSB    = 31;
    localparam int unsigned ANGLE_LSB    = 16;
    localparam int unsigned CH_FIELD_LSB = 16;

    // (base + off) mod n, valid for base < n and off <= n.
    function automatic logic [2:0] wrap_add(input logic [2:0] base, input int unsigned off,
                                            input int unsigned n);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= n) begin
            s = s - n;
        end
        return 3'(s);
    endfunction

endpackage

// File: rtl/demod_stream_arbiter_if.sv
// demod_stream_arbiter_if: all stream signals around the arbiter.
//   ch_enable, s_axis_*   - per-channel CORDIC angle streams (packed N_CH lanes)
//   dm_axis_*             - beats issued to the demodulator
//   dr_axis_*             - results returned by the demodulator
//   m00_axis_*            - tagged results to the audio/DMA sink
//   err_underflow         - sticky result-without-tag flag
// slave is the arbiter's view; master is the surrounding environment.
interface demod_stream_arbiter_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0]    ch_enable;
    logic [N_CH*32-1:0] s_axis_tdata;
    logic [N_CH-1:0]    s_axis_tvalid;
    logic [N_CH-1:0]    s_axis_tlast;
    logic [N_CH-1:0]    s_axis_tready;

    logic [31:0]        dm_axis_tdata;
    logic               dm_axis_tvalid;
    logic               dm_axis_tlast;
    logic               dm_axis_tready;

    logic [31:0]        dr_axis_tdata;
    logic               dr_axis_tvalid;
    logic               dr_axis_tlast;
    logic               dr_axis_tready;

    logic [31:0]        m00_axis_tdata;
    logic               m00_axis_tvalid;
    logic               m00_axis_tlast;
    logic               m00_axis_tready;

    logic               err_underflow;

    modport slave (
        input  ch_enable, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output dm_axis_tdata, dm_axis_tvalid, dm_axis_tlast,
        input  dm_axis_tready,
        input  dr_axis_tdata, dr_axis_tvalid, dr_axis_tlast,
        output dr_axis_tready,
        output m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast,
        input  m00_axis_tready,
        output err_underflow
    );

    modport master (
        output ch_enable, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  dm_axis_tdata, dm_axis_tvalid, dm_axis_tlast,
        output dm_axis_tready,
        output dr_axis_tdata, dr_axis_tvalid, dr_axis_tlast,
        input  dr_axis_tready,
        input  m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast,
        output m00_axis_tready,
        input  err_underflow
    );

endinterface

// File: rtl/demod_stream_arbiter_tag_fifo.sv
// demod_tag_fifo: synchronous FIFO of tag_t entries tracking beats in flight
// through the demodulator.
//   clk, rst       - clock, asynchronous active-high reset (empties the FIFO)
//   push, push_tag - write request and data (ignored when full)
//   pop            - read request (ignored when empty)
//   head           - oldest entry
//   full, empty    - occupancy flags
module demod_tag_fifo
    import demod_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_t push_tag,
    input  logic pop,
    output tag_t head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tag_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_tag;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/demod_stream_arbiter.sv
// demod_stream_arbiter: round-robin packet arbiter sharing one stateful FM
// demodulator between N_CH angle streams. On each channel switch a priming beat
// carrying the new channel's last angle is issued and its result discarded.
//   s00_axis_aclk   - clock
//   s00_axis_areset - asynchronous active-high reset
//   bus (slave)     - s_axis_* inputs, dm_axis_* to demodulator, dr_axis_* from
//                     demodulator, m00_axis_* tagged output, err_underflow
module demod_stream_arbiter
    import demod_arb_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                   s00_axis_aclk,
    input  logic                   s00_axis_areset,
    demod_stream_arbiter_if.slave  bus
);

    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e            state_q, state_d;
    logic [2:0]        ch_q, ch_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        last_ch_q, last_ch_d;
    logic [15:0]       last_angle_q [N_CH];
    logic              err_q, err_d;

    logic [SEL_W-1:0]  ch_sel;
    logic [31:0]       beat_data [N_CH];
    logic [N_CH-1:0]   cand;
    logic              found;
    logic [2:0]        winner;

    logic [N_CH-1:0]   s_tready;
    logic [31:0]       dm_tdata;
    logic              dm_tvalid;
    logic              dm_tlast;
    logic              angle_we;

    logic              tag_push;
    tag_t              tag_push_val;
    logic              tag_pop;
    tag_t              tag_head;
    logic              tag_full;
    logic              tag_empty;

    logic              dr_tready;
    logic              m00_tvalid;
    logic [31:0]       m00_tdata;
    logic              underflow;
    logic              unused_dr;

    assign ch_sel    = ch_q[SEL_W-1:0];
    assign unused_dr = ^bus.dr_axis_tdata[31:16];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            beat_data[i] = bus.s_axis_tdata[i*32 +: 32];
        end
    end

    // First enabled requester at or after rr_ptr, searching upward with wrap.
    always_comb begin
        cand   = bus.s_axis_tvalid & bus.ch_enable;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && cand[wrap_add(rr_ptr_q, i, N_CH)]) begin
                found  = 1'b1;
                winner = wrap_add(rr_ptr_q, i, N_CH);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        rr_ptr_d     = rr_ptr_q;
        last_ch_d    = last_ch_q;
        s_tready     = '0;
        dm_tdata     = '0;
        dm_tvalid    = 1'b0;
        dm_tlast     = 1'b0;
        angle_we     = 1'b0;
        tag_push     = 1'b0;
        tag_push_val = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    ch_d    = winner;
                    state_d = (winner == last_ch_q) ? STREAM : PRIME;
                end
            end
            PRIME: begin
                // Re-seed the demodulator's difference history with this channel's angle.
                dm_tdata  = {last_angle_q[ch_sel], 16'h0000};
                dm_tvalid = ~tag_full;
                if (dm_tvalid && bus.dm_axis_tready) begin
                    tag_push     = 1'b1;
                    tag_push_val = '{drop: 1'b1, ch: ch_q};
                    last_ch_d    = ch_q;
                    state_d      = STREAM;
                end
            end
            STREAM: begin
                dm_tdata         = beat_data[ch_sel];
                dm_tlast         = bus.s_axis_tlast[ch_sel];
                dm_tvalid        = bus.s_axis_tvalid[ch_sel] & ~tag_full;
                s_tready[ch_sel] = bus.dm_axis_tready & ~tag_full;
                if (bus.s_axis_tvalid[ch_sel] && s_tready[ch_sel]) begin
                    tag_push     = 1'b1;
                    tag_push_val = '{drop: 1'b0, ch: ch_q};
                    angle_we     = 1'b1;
                    last_ch_d    = ch_q;
                    if (bus.s_axis_tlast[ch_sel]) begin
                        rr_ptr_d = wrap_add(ch_q, 1, N_CH);
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            rr_ptr_q  <= '0;
            last_ch_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                last_angle_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            rr_ptr_q  <= rr_ptr_d;
            last_ch_q <= last_ch_d;
            err_q     <= err_d;
            if (angle_we) begin
                last_angle_q[ch_sel] <= beat_data[ch_sel][ANGLE_MSB:ANGLE_LSB];
            end
        end
    end

    // Result side: steered only by the tag at the FIFO head, independent of the FSM.
    always_comb begin
        dr_tready  = 1'b0;
        m00_tvalid = 1'b0;
        tag_pop    = 1'b0;
        underflow  = 1'b0;
        if (tag_empty) begin
            dr_tready = 1'b1;
            underflow = bus.dr_axis_tvalid;
        end else if (tag_head.drop) begin
            dr_tready = 1'b1;
            tag_pop   = bus.dr_axis_tvalid;
        end else begin
            dr_tready  = bus.m00_axis_tready;
            m00_tvalid = bus.dr_axis_tvalid;
            tag_pop    = bus.dr_axis_tvalid & bus.m00_axis_tready;
        end
        // Nothing handshakes while reset is held.
        if (s00_axis_areset) begin
            dr_tready  = 1'b0;
            m00_tvalid = 1'b0;
            tag_pop    = 1'b0;
            underflow  = 1'b0;
        end
    end

    always_comb begin
        m00_tdata                      = '0;
        m00_tdata[15:0]                = bus.dr_axis_tdata[15:0];
        m00_tdata[CH_FIELD_LSB +: 3]   = tag_head.ch;
    end

    assign err_d = err_q | underflow;

    demod_tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (s00_axis_aclk),
        .rst      (s00_axis_areset),
        .push     (tag_push),
        .push_tag (tag_push_val),
        .pop      (tag_pop),
        .head     (tag_head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    assign bus.s_axis_tready   = s_tready;
    assign bus.dm_axis_tdata   = dm_tdata;
    assign bus.dm_axis_tvalid  = dm_tvalid;
    assign bus.dm_axis_tlast   = dm_tlast;
    assign bus.dr_axis_tready  = dr_tready;
    assign bus.m00_axis_tdata  = m00_tdata;
    assign bus.m00_axis_tvalid = m00_tvalid;
    assign bus.m00_axis_tlast  = bus.dr_axis_tlast;
    assign bus.err_underflow   = err_q;

endmodule
